// File: rtl/fetch_queue_pkg.sv
// Shared fetch/decode definitions: datapath width, canonical NOP and the
// layout of one buffered fetch entry.
`timescale 1ns/1ps
package fetch_queue_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0 -- also used by decode when inserting bubbles
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_step;
    logic            err;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode. Circular buffer of fetched
// words with PC/PC+4, flushed on redirect, NOP presented when empty.
`timescale 1ns/1ps
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int              DEPTH     = 4,
  parameter logic [XLEN-1:0] NOP_INSTR = fetch_queue_pkg::NOP_INSTR
) (
  input  logic                     clk,
  input  logic                     rst,
  // Handshake: a transfer happens on a side when valid & ready are both high
  // at a rising edge and flush is low; ready never depends on the other side.
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_instr,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_pc_step,
  input  logic                     in_err,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_instr,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_pc_step,
  output logic                     out_err,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  fq_entry_t     mem_q [DEPTH];
  fq_entry_t     head;
  logic          full, empty, push, pop;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);

  always_comb begin
    push     = in_valid & ~full & ~flush;
    pop      = ~empty & out_ready & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is deliberately left unreset; empty slots are masked at the output.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{instr: in_instr, pc: in_pc, pc_step: in_pc_step, err: in_err};
    end
  end

  assign head        = mem_q[rd_ptr_q];
  assign in_ready    = ~full;
  assign out_valid   = ~empty;
  assign out_instr   = empty ? NOP_INSTR : head.instr;
  assign out_pc      = empty ? '0 : head.pc;
  assign out_pc_step = empty ? '0 : head.pc_step;
  assign out_err     = empty ? 1'b0 : head.err;
  assign count       = cnt_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus a randomized
// run, all checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_fetch_queue;

  localparam int          DEPTH = 4;
  localparam int          EW    = 97;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk, rst;
  logic        in_valid, in_ready, in_err, flush;
  logic [31:0] in_instr, in_pc, in_pc_step;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_instr, out_pc, out_pc_step;
  logic [2:0]  count;

  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  fetch_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .in_pc_step(in_pc_step), .in_err(in_err), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_step(out_pc_step), .out_err(out_err),
    .count(count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [31:0] instr,
                       input logic [31:0] pc, input logic err,
                       input logic rdy, input logic fl);
    in_valid   = v;
    in_instr   = instr;
    in_pc      = pc;
    in_pc_step = pc + 32'd4;
    in_err     = err;
    out_ready  = rdy;
    flush      = fl;
  endtask

  // Advance one clock; the model applies the queue rules to the inputs seen at the edge.
  task automatic tick();
    logic do_push, do_pop;
    @(posedge clk);
    if (flush) begin
      exp_q.delete();
    end else begin
      do_pop  = (exp_q.size() != 0) && out_ready;
      do_push = in_valid && (exp_q.size() < DEPTH);
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({in_instr, in_pc, in_pc_step, in_err});
    end
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_cmp++;
    if (out_valid !== 1'b0 || out_instr !== NOP || count !== 3'd0 || in_ready !== 1'b1
        || out_pc !== 32'd0 || out_pc_step !== 32'd0 || out_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_init: valid=%b instr=%h cnt=%0d rdy=%b pc=%h step=%h err=%b, want 0/%h/0/1/0/0/0",
               out_valid, out_instr, count, in_ready, out_pc, out_pc_step, out_err, NOP);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h55 + i, 32'h1000 + 4*i, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (count !== 3'd3) begin
      n_err++;
      $display("FAIL reset_precount: count=%0d want 3", count);
    end
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_instr !== NOP || count !== 3'd0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_async: valid=%b instr=%h cnt=%0d rdy=%b, want 0/%h/0/1",
               out_valid, out_instr, count, in_ready, NOP);
    end
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hA0 + i, 32'h4 * i, 1'b0, 1'b0, 1'b0);
      tick();
    end
    n_cmp++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL fill_full: count=%0d rdy=%b want 4/0", count, in_ready);
    end
    drive(1'b1, 32'hA4, 32'h10, 1'b0, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if (count !== 3'd4 || out_instr !== 32'hA0) begin
      n_err++;
      $display("FAIL fill_fifth_ignored: count=%0d head=%h want 4/a0", count, out_instr);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_instr !== 32'hA0 + i || out_pc !== 32'h4 * i) begin
        n_err++;
        $display("FAIL drain_order[%0d]: valid=%b instr=%h pc=%h want 1/%h/%h",
                 i, out_valid, out_instr, out_pc, 32'hA0 + i, 32'h4 * i);
      end
      tick();
    end
    n_cmp++;
    if (out_valid !== 1'b0 || out_instr !== NOP || count !== 3'd0) begin
      n_err++;
      $display("FAIL drain_empty: valid=%b instr=%h cnt=%0d want 0/%h/0", out_valid, out_instr, count, NOP);
    end
  endtask

  task automatic test_stream_wrap();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'hB00 + i, 32'h100 + 4*i, 1'b0, 1'b1, 1'b0);
      tick();
      n_cmp++;
      if (count !== 3'd1 || out_valid !== 1'b1 || out_pc !== 32'h100 + 4*i
          || out_pc_step !== 32'h104 + 4*i) begin
        n_err++;
        $display("FAIL stream[%0d]: cnt=%0d valid=%b pc=%h step=%h want 1/1/%h/%h",
                 i, count, out_valid, out_pc, out_pc_step, 32'h100 + 4*i, 32'h104 + 4*i);
      end
    end
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hC0 + i, 32'h500 + 4*i, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'hC4, 32'h510, 1'b0, 1'b1, 1'b0);
    tick();
    n_cmp++;
    if (count !== 3'd3 || out_pc !== 32'h504 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL full_pop_no_push: cnt=%0d pc=%h rdy=%b want 3/504/1", count, out_pc, in_ready);
    end
    drive(1'b1, 32'hC5, 32'h514, 1'b0, 1'b1, 1'b0);
    tick();
    n_cmp++;
    if (count !== 3'd3 || out_pc !== 32'h508) begin
      n_err++;
      $display("FAIL full_pop_both: cnt=%0d pc=%h want 3/508", count, out_pc);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (out_pc !== 32'h508 + 4*i + ((i == 2) ? 32'h4 : 32'h0)) begin
        n_err++;
        $display("FAIL full_pop_drain[%0d]: pc=%h want %h", i, out_pc,
                 32'h508 + 4*i + ((i == 2) ? 32'h4 : 32'h0));
      end
      tick();
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hD0 + i, 32'h600 + 4*i, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'hDD, 32'h200, 1'b0, 1'b1, 1'b1);
    tick();
    n_cmp++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_instr !== NOP || out_pc !== 32'd0) begin
      n_err++;
      $display("FAIL flush_clear: cnt=%0d valid=%b instr=%h pc=%h want 0/0/%h/0",
               count, out_valid, out_instr, out_pc, NOP);
    end
    drive(1'b1, 32'hEE, 32'h300, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_no_bypass: valid=%b want 0", out_valid);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 32'h300 || count !== 3'd1) begin
      n_err++;
      $display("FAIL flush_next_head: valid=%b pc=%h cnt=%0d want 1/300/1", out_valid, out_pc, count);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hF0 + i, 32'h700 + 4*i, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'hFF, 32'h800, 1'b0, 1'b0, 1'b1);
    tick();
    n_cmp++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL flush_full: cnt=%0d valid=%b rdy=%b want 0/0/1", count, out_valid, in_ready);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_err();
    drive(1'b1, 32'h11, 32'h40, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h22, 32'h44, 1'b0, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if (out_err !== 1'b1 || out_pc !== 32'h40) begin
      n_err++;
      $display("FAIL err_head: err=%b pc=%h want 1/40", out_err, out_pc);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    tick();
    n_cmp++;
    if (out_err !== 1'b0 || out_pc !== 32'h44) begin
      n_err++;
      $display("FAIL err_next: err=%b pc=%h want 0/44", out_err, out_pc);
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] e_instr, e_pc, e_step;
    logic        e_err, e_valid;
    logic [2:0]  e_cnt;
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 19) == 0));
      tick();
      e_valid = (exp_q.size() != 0);
      e_cnt   = 3'(exp_q.size());
      if (e_valid) {e_instr, e_pc, e_step, e_err} = exp_q[0];
      else {e_instr, e_pc, e_step, e_err} = {NOP, 32'd0, 32'd0, 1'b0};
      n_cmp++;
      if (out_valid !== e_valid || count !== e_cnt || in_ready !== (exp_q.size() != DEPTH)) begin
        n_err++;
        $display("FAIL rand_ctrl[%0d]: valid=%b cnt=%0d rdy=%b want %b/%0d/%b",
                 c, out_valid, count, in_ready, e_valid, e_cnt, exp_q.size() != DEPTH);
      end
      n_cmp++;
      if (out_instr !== e_instr || out_pc !== e_pc || out_pc_step !== e_step || out_err !== e_err) begin
        n_err++;
        $display("FAIL rand_head[%0d]: got %h/%h/%h/%b want %h/%h/%h/%b",
                 c, out_instr, out_pc, out_pc_step, out_err, e_instr, e_pc, e_step, e_err);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    test_reset();
    test_fill_drain();
    test_stream_wrap();
    test_full_pop();
    test_flush();
    test_err();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
